// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scan controller.
// Scans up to DIGITS digits from one shared set of segment lines. It supports hex decode
// or raw patterns, per-digit decimal points, PWM brightness and leading-zero blanking.
// All display inputs are captured into shadow registers at each frame start, so a
// frame never shows a mix of old and new data.
module seg_scan_ctrl #(
    parameter int  DIGITS         = 8,
    parameter int  SCAN_LOG2      = 16,
    parameter int  BRIGHT_W       = 4,
    parameter bit  AN_ACTIVE_LOW  = 1'b1,
    parameter bit  SEG_ACTIVE_LOW = 1'b1,
    localparam int IW             = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int NW             = $clog2(DIGITS) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [4*DIGITS-1:0]   hex,
    input  logic [8*DIGITS-1:0]   raw,
    input  logic                  mode,
    input  logic [DIGITS-1:0]     dp,
    input  logic [NW-1:0]         n,
    input  logic [BRIGHT_W-1:0]   bright,
    input  logic                  lzb,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [IW-1:0]         digit_idx,
    output logic                  frame_tick
);

    localparam logic [SCAN_LOG2-1:0] CNT_MAX = {SCAN_LOG2{1'b1}};
    localparam logic [DIGITS-1:0]    AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]           SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    // Active-high g..a pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            4'hF:    hex7 = 7'h71;
            default: hex7 = 7'h00;
        endcase
    endfunction

    // Scan state; start_q is clear until the first edge after reset has loaded the shadow.
    logic                 start_q, start_d;
    logic [SCAN_LOG2-1:0] cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 load_s;

    // Shadow copies of the display inputs.
    logic [4*DIGITS-1:0]  hex_q;
    logic [8*DIGITS-1:0]  raw_q;
    logic                 mode_q;
    logic [DIGITS-1:0]    dp_q;
    logic [NW-1:0]        n_q, n_clamp_s;
    logic [BRIGHT_W-1:0]  bright_q;
    logic                 lzb_q;

    // Output next values, before polarity.
    logic [DIGITS-1:0]    an_d;
    logic [7:0]           seg_d;
    logic                 ft_d;
    logic                 on_s;
    logic                 blank_s;
    logic [7:0]           pat_s;
    logic [BRIGHT_W-1:0]  phase_s;
    int                   k_s;

    // Slot counter, digit index and frame-start detection.
    always_comb begin
        start_d = 1'b1;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        load_s  = 1'b0;
        if (!start_q) begin
            load_s = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_MAX) begin
                if ((n_q == {NW{1'b0}}) || (int'(idx_q) + 1 >= int'(n_q))) begin
                    idx_d  = {IW{1'b0}};
                    load_s = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                idx_d = idx_q;
            end
        end
        n_clamp_s = (int'(n) > DIGITS) ? NW'(DIGITS) : n;
    end

    // Digit pattern, blanking, PWM gating and frame pulse for the current state.
    always_comb begin
        k_s = 0;
        for (int i = 0; i < DIGITS; i++) begin
            k_s = ((i < int'(n_q)) && (hex_q[4*i +: 4] != 4'h0)) ? i : k_s;
        end
        blank_s = lzb_q && (int'(idx_q) > k_s);
        phase_s = cnt_q[SCAN_LOG2-1 -: BRIGHT_W];
        on_s    = start_q && (n_q != {NW{1'b0}}) && (phase_s <= bright_q);
        if (mode_q) begin
            pat_s = raw_q[8*int'(idx_q) +: 8];
        end else if (blank_s) begin
            pat_s = 8'h00;
        end else begin
            pat_s = {dp_q[idx_q], hex7(hex_q[4*int'(idx_q) +: 4])};
        end
        an_d        = {DIGITS{1'b0}};
        an_d[idx_q] = on_s;
        seg_d       = on_s ? pat_s : 8'h00;
        ft_d        = start_q && (cnt_q == {SCAN_LOG2{1'b0}}) && (idx_q == {IW{1'b0}});
    end

    // State, shadow and polarity-corrected output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            start_q    <= 1'b0;
            cnt_q      <= {SCAN_LOG2{1'b0}};
            idx_q      <= {IW{1'b0}};
            hex_q      <= {(4*DIGITS){1'b0}};
            raw_q      <= {(8*DIGITS){1'b0}};
            mode_q     <= 1'b0;
            dp_q       <= {DIGITS{1'b0}};
            n_q        <= {NW{1'b0}};
            bright_q   <= {BRIGHT_W{1'b0}};
            lzb_q      <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            digit_idx  <= {IW{1'b0}};
            frame_tick <= 1'b0;
        end else begin
            start_q <= start_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (load_s) begin
                hex_q    <= hex;
                raw_q    <= raw;
                mode_q   <= mode;
                dp_q     <= dp;
                n_q      <= n_clamp_s;
                bright_q <= bright;
                lzb_q    <= lzb;
            end else begin
                hex_q    <= hex_q;
                raw_q    <= raw_q;
                mode_q   <= mode_q;
                dp_q     <= dp_q;
                n_q      <= n_q;
                bright_q <= bright_q;
                lzb_q    <= lzb_q;
            end
            an         <= AN_ACTIVE_LOW ? ~an_d : an_d;
            seg        <= SEG_ACTIVE_LOW ? ~seg_d : seg_d;
            digit_idx  <= idx_q;
            frame_tick <= ft_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (4 digits, 16-cycle slots, 2-bit brightness, active-low).
// Stimulus pushes one expected record per digit slot; a monitor summarises each slot
// it observes and compares it with the record at the head of the queue.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] hex;
    logic [31:0] raw;
    logic        mode;
    logic [3:0]  dp;
    logic [2:0]  n;
    logic [1:0]  bright;
    logic        lzb;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    seg_scan_ctrl #(
        .DIGITS(4), .SCAN_LOG2(4), .BRIGHT_W(2), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rstn(rstn), .hex(hex), .raw(raw), .mode(mode), .dp(dp), .n(n),
        .bright(bright), .lzb(lzb), .seg(seg), .an(an), .digit_idx(digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [3:0] an_on;
        logic [7:0] seg_on;
        int         on;
        bit         ft;
        bit         sync;
    } rec_t;

    rec_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   collecting = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic push(input int idx, input logic [3:0] a, input logic [7:0] s,
                        input int on, input bit ft, input bit sync);
        rec_t r;
        r.idx = idx; r.an_on = a; r.seg_on = s; r.on = on; r.ft = ft; r.sync = sync;
        q.push_back(r);
    endtask

    // Four-digit frame; segment values are the DUT outputs while each digit is lit.
    task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3,
                              input int on, input bit sync);
        push(0, 4'hE, s0, on, 1'b1, sync);
        push(1, 4'hD, s1, on, 1'b0, 1'b0);
        push(2, 4'hB, s2, on, 1'b0, 1'b0);
        push(3, 4'h7, s3, on, 1'b0, 1'b0);
    endtask

    task automatic wait_ft(input string name);
        int t = 0;
        do begin
            @(negedge clk); #1; t++;
        end while (!frame_tick && t < 300);
        if (!frame_tick) timeout(name);
    endtask

    task automatic wait_idx(input logic [1:0] v, input string name);
        int t = 0;
        do begin
            @(negedge clk); #1; t++;
        end while (digit_idx != v && t < 300);
        if (digit_idx != v) timeout(name);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((q.size() > 0 || collecting) && t < 1000) begin
            @(negedge clk); #1; t++;
        end
        if (q.size() > 0 || collecting) begin
            timeout(name);
            q.delete();
        end
    endtask

    // Monitor: slices the output stream into slots and checks each against the queue.
    rec_t       cur;
    int         c, oncnt, gap, bad, ft_v, idx_v;
    bit         seen_off, have_prev, start;
    logic [1:0] prev_idx;
    logic [3:0] an_v;
    logic [7:0] seg_v;

    always @(negedge clk) begin
        if (!mon_en) begin
            collecting = 1'b0;
            have_prev  = 1'b0;
        end else begin
            start = frame_tick || (have_prev && digit_idx != prev_idx);
            if (start && collecting) begin
                chk("slot_idx",    idx_v, cur.idx);
                chk("slot_ftick",  ft_v, int'(cur.ft));
                chk("slot_len",    c, 16);
                chk("slot_on",     oncnt, cur.on);
                chk("slot_an",     int'(an_v), int'(cur.an_on));
                chk("slot_seg",    int'(seg_v), int'(cur.seg_on));
                chk("slot_pwmgap", gap, 0);
                chk("slot_glitch", bad, 0);
                collecting = 1'b0;
            end
            if (start && q.size() > 0 && (!q[0].sync || frame_tick)) begin
                cur        = q.pop_front();
                collecting = 1'b1;
                c = 0; oncnt = 0; gap = 0; bad = 0; seen_off = 1'b0;
                an_v = 4'hF; seg_v = 8'hFF;
                ft_v = int'(frame_tick); idx_v = int'(digit_idx);
            end
            if (collecting) begin
                c++;
                if (an != 4'hF) begin
                    if (seen_off) gap++;
                    if ($countones(~an) != 1) bad++;
                    if (oncnt > 0 && (an != an_v || seg != seg_v)) bad++;
                    an_v = an;
                    seg_v = seg;
                    oncnt++;
                end else begin
                    seen_off = 1'b1;
                    if (seg != 8'hFF) bad++;
                end
            end
            prev_idx  = digit_idx;
            have_prev = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; hex = 16'h1234; raw = 32'h0; mode = 1'b0; dp = 4'b0001;
        n = 3'd4; bright = 2'd3; lzb = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_an", int'(an), 4'hF);
        chk("rst_seg", int'(seg), 8'hFF);
        chk("rst_idx", int'(digit_idx), 0);
        chk("rst_ft", int'(frame_tick), 0);
        rstn = 1'b1;
        mon_en = 1'b1;

        // Hex 1234, dp on digit 0, full brightness: digits 4,3,2,1 with dp on digit 0.
        wait_ft("ft_t1");
        push_frame(8'h19, 8'hB0, 8'hA4, 8'hF9, 16, 1'b1);
        push_frame(8'h19, 8'hB0, 8'hA4, 8'hF9, 16, 1'b0);
        drain("drain_t1");

        // Minimum brightness: 4 of 16 cycles lit, at slot start.
        wait_ft("ft_t2");
        bright = 2'd0;
        push_frame(8'h19, 8'hB0, 8'hA4, 8'hF9, 4, 1'b1);
        push_frame(8'h19, 8'hB0, 8'hA4, 8'hF9, 4, 1'b0);
        drain("drain_t2");

        // Leading-zero blanking of 0050; dp on blanked digit 3 is suppressed.
        wait_ft("ft_t3");
        bright = 2'd3; hex = 16'h0050; lzb = 1'b1; dp = 4'b1000;
        push_frame(8'hC0, 8'h92, 8'hFF, 8'hFF, 16, 1'b1);
        drain("drain_t3");

        // All-zero value: only digit 0 shows a 0.
        wait_ft("ft_t4");
        hex = 16'h0000;
        push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 16, 1'b1);
        drain("drain_t4");

        // Raw mode: patterns pass through; dp and lzb have no effect.
        wait_ft("ft_t5");
        mode = 1'b1; raw = 32'h81A53C7E; dp = 4'hF;
        push_frame(8'h81, 8'hC3, 8'h5A, 8'h7E, 16, 1'b1);
        drain("drain_t5");

        // n = 0: nothing lit, frame_tick once per 16-cycle slot.
        wait_ft("ft_t6");
        n = 3'd0;
        push(0, 4'hF, 8'hFF, 0, 1'b1, 1'b1);
        push(0, 4'hF, 8'hFF, 0, 1'b1, 1'b0);
        push(0, 4'hF, 8'hFF, 0, 1'b1, 1'b0);
        drain("drain_t6");

        // Mid-frame change of n and hex: current frame completes with the old data.
        wait_ft("ft_t7");
        mode = 1'b0; n = 3'd4; hex = 16'h1234; dp = 4'b0000; lzb = 1'b0;
        push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 16, 1'b1);
        push(0, 4'hE, 8'h83, 16, 1'b1, 1'b0);
        push(1, 4'hD, 8'h88, 16, 1'b0, 1'b0);
        push(0, 4'hE, 8'h83, 16, 1'b1, 1'b0);
        push(1, 4'hD, 8'h88, 16, 1'b0, 1'b0);
        wait_ft("ft_t7b");
        wait_idx(2'd2, "idx_t7");
        n = 3'd2; hex = 16'h00AB;
        drain("drain_t7");

        // n above DIGITS clamps to 4 digits.
        wait_ft("ft_t8");
        n = 3'd5; hex = 16'h1234; dp = 4'b0001;
        push_frame(8'h19, 8'hB0, 8'hA4, 8'hF9, 16, 1'b1);
        drain("drain_t8");

        // Reset in the middle of the digit 2 slot, then restart timing.
        wait_idx(2'd2, "idx_t9");
        mon_en = 1'b0;
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk); #1;
        chk("mid_rst_an", int'(an), 4'hF);
        chk("mid_rst_seg", int'(seg), 8'hFF);
        chk("mid_rst_idx", int'(digit_idx), 0);
        chk("mid_rst_ft", int'(frame_tick), 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #1;
        chk("rel1_ft", int'(frame_tick), 0);
        chk("rel1_an", int'(an), 4'hF);
        @(negedge clk); #1;
        chk("rel2_ft", int'(frame_tick), 1);
        chk("rel2_an", int'(an), 4'hE);
        chk("rel2_idx", int'(digit_idx), 0);
        chk("rel2_seg", int'(seg), 8'h19);
        mon_en = 1'b1;
        push_frame(8'h19, 8'hB0, 8'hA4, 8'hF9, 16, 1'b1);
        drain("drain_t9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
